// File: rtl/data_sender_pkg.sv
// Shared constants and state encoding for the PC-link frame sender.
// DATA_SENDER_CHECKSUM_EN adds a trailing checksum byte to the trailer frame.
package data_sender_pkg;

  localparam logic [7:0] SOF_BYTE   = 8'hAA;
  localparam logic [7:0] EOF_BYTE   = 8'h55;
  localparam int         FIFO_DEPTH = 4;
  localparam int         FIFO_WIDTH = 34;
  localparam int         HDR_LEN    = 5;
`ifdef DATA_SENDER_CHECKSUM_EN
  localparam int         TRL_LEN    = 4;
`else
  localparam int         TRL_LEN    = 3;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    TRL  = 2'd3
  } state_t;

endpackage

// File: rtl/send_fifo.sv
// Small show-ahead FIFO of queued data words; head entry is visible on dout while not empty.
// Pushes are ignored when full, pops when empty.
module send_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_sender_sm.sv
// Byte-serial frame sender: header, queued data words and trailer over a valid/ready byte link.
// Defining DATA_SENDER_CHECKSUM_EN appends an XOR checksum of the data bytes to the trailer.
module data_sender_sm
  import data_sender_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] CMD,
  input  logic        SEND_HEADER,
  input  logic        SEND_DATA,
  input  logic        SEND_TRAILER,
  input  logic [31:0] DATA_IN,
  input  logic [1:0]  DATA_NBYTES,
  output logic        BUSY_SEND,
  output logic [7:0]  TX_BYTE,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        OVERFLOW
);

  state_t      state_reg;
  logic        hdr_pend_reg;
  logic        trl_pend_reg;
  logic [31:0] cmd_reg;
  logic [31:0] shift_reg;
  logic [2:0]  left_reg;
  logic [15:0] word_count_reg;
  logic        overflow_reg;
  logic [7:0]  tx_byte_reg;
  logic        tx_valid_reg;
`ifdef DATA_SENDER_CHECKSUM_EN
  logic [7:0]  checksum_reg;
`endif

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic [1:0]            head_nbytes;
  logic [31:0]           head_data;
  logic [4:0]            head_base;
  logic [5:0]            head_shamt;
  logic                  xfer;

  send_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .din   ({DATA_NBYTES, DATA_IN}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A word arriving while full is lost even if a pop happens in the same cycle.
  assign fifo_push   = SEND_DATA && !fifo_full;
  assign fifo_pop    = (state_reg == IDLE) && !hdr_pend_reg && !fifo_empty;
  assign head_nbytes = fifo_dout[33:32];
  assign head_data   = fifo_dout[31:0];
  assign head_base   = {head_nbytes, 3'b000};
  assign head_shamt  = 6'd32 - {1'b0, head_base};
  assign xfer        = tx_valid_reg && TX_READY;

  assign TX_BYTE   = tx_byte_reg;
  assign TX_VALID  = tx_valid_reg;
  assign OVERFLOW  = overflow_reg;
  assign BUSY_SEND = (state_reg != IDLE) || hdr_pend_reg || trl_pend_reg || !fifo_empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= IDLE;
      hdr_pend_reg   <= 1'b0;
      trl_pend_reg   <= 1'b0;
      cmd_reg        <= '0;
      shift_reg      <= '0;
      left_reg       <= '0;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
      tx_byte_reg    <= 8'h00;
      tx_valid_reg   <= 1'b0;
`ifdef DATA_SENDER_CHECKSUM_EN
      checksum_reg   <= 8'h00;
`endif
    end else begin
      if (SEND_HEADER && !hdr_pend_reg) begin
        hdr_pend_reg <= 1'b1;
        cmd_reg      <= CMD;
      end
      if (SEND_TRAILER && !trl_pend_reg) trl_pend_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (hdr_pend_reg) begin
            state_reg      <= HDR;
            hdr_pend_reg   <= 1'b0;
            tx_valid_reg   <= 1'b1;
            tx_byte_reg    <= SOF_BYTE;
            shift_reg      <= cmd_reg;
            left_reg       <= 3'(HDR_LEN - 1);
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
`ifdef DATA_SENDER_CHECKSUM_EN
            checksum_reg   <= 8'h00;
`endif
          end else if (!fifo_empty) begin
            // Most significant selected byte goes out first; the rest wait left-aligned.
            state_reg    <= DATA;
            tx_valid_reg <= 1'b1;
            tx_byte_reg  <= head_data[head_base +: 8];
            shift_reg    <= head_data << head_shamt;
            left_reg     <= {1'b0, head_nbytes};
          end else if (trl_pend_reg) begin
            state_reg    <= TRL;
            trl_pend_reg <= 1'b0;
            tx_valid_reg <= 1'b1;
            tx_byte_reg  <= EOF_BYTE;
`ifdef DATA_SENDER_CHECKSUM_EN
            shift_reg    <= {word_count_reg, checksum_reg, 8'h00};
`else
            shift_reg    <= {word_count_reg, 16'h0000};
`endif
            left_reg     <= 3'(TRL_LEN - 1);
          end
        end
        default: begin
          if (xfer) begin
`ifdef DATA_SENDER_CHECKSUM_EN
            if (state_reg == DATA) checksum_reg <= checksum_reg ^ tx_byte_reg;
`endif
            if (left_reg == 3'd0) begin
              state_reg    <= IDLE;
              tx_valid_reg <= 1'b0;
              if (state_reg == DATA && word_count_reg != 16'hFFFF)
                word_count_reg <= word_count_reg + 16'd1;
            end else begin
              tx_byte_reg <= shift_reg[31:24];
              shift_reg   <= {shift_reg[23:0], 8'h00};
              left_reg    <= left_reg - 3'd1;
            end
          end
        end
      endcase

      if (SEND_DATA && fifo_full) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sender_sm.sv
// Self-checking bench for data_sender_sm: directed frame cases plus randomized frames with random link stalls.
// Expected byte streams come from a frame-level model; build with DATA_SENDER_CHECKSUM_EN to expect the checksum byte.
module tb_data_sender_sm;

  logic        CLK;
  logic        RST_N;
  logic [31:0] CMD;
  logic        SEND_HEADER;
  logic        SEND_DATA;
  logic        SEND_TRAILER;
  logic [31:0] DATA_IN;
  logic [1:0]  DATA_NBYTES;
  logic        BUSY_SEND;
  logic [7:0]  TX_BYTE;
  logic        TX_VALID;
  logic        TX_READY;
  logic        OVERFLOW;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;

  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [15:0] m_wc = 16'h0;
  logic [7:0]  m_cs = 8'h00;

  logic       stall_prev = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  data_sender_sm dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CMD          (CMD),
    .SEND_HEADER  (SEND_HEADER),
    .SEND_DATA    (SEND_DATA),
    .SEND_TRAILER (SEND_TRAILER),
    .DATA_IN      (DATA_IN),
    .DATA_NBYTES  (DATA_NBYTES),
    .BUSY_SEND    (BUSY_SEND),
    .TX_BYTE      (TX_BYTE),
    .TX_VALID     (TX_VALID),
    .TX_READY     (TX_READY),
    .OVERFLOW     (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Link side: 0 = never ready, 1 = always ready, otherwise random per cycle.
  initial begin
    TX_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      case (ready_mode)
        0:       TX_READY = 1'b0;
        1:       TX_READY = 1'b1;
        default: TX_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Byte capture and hold-while-stalled checking.
  always @(negedge CLK) begin
    if (!RST_N) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(TX_VALID), 32'd1);
        chk("hold_byte", 32'(TX_BYTE), 32'(stall_byte));
      end
      if (TX_VALID && TX_READY) rx_q.push_back(TX_BYTE);
      stall_prev = TX_VALID && !TX_READY;
      stall_byte = TX_BYTE;
    end
  end

  // Frame-level reference model.
  task automatic exp_hdr(input logic [31:0] c);
    exp_q.push_back(8'hAA);
    exp_q.push_back(c[31:24]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    m_wc = 16'h0;
    m_cs = 8'h00;
  endtask

  task automatic exp_data(input logic [31:0] d, input logic [1:0] n);
    for (int i = int'(n); i >= 0; i--) begin
      logic [7:0] b;
      b = d[8*i +: 8];
      exp_q.push_back(b);
      m_cs = m_cs ^ b;
    end
    if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
  endtask

  task automatic exp_trl();
    exp_q.push_back(8'h55);
    exp_q.push_back(m_wc[15:8]);
    exp_q.push_back(m_wc[7:0]);
`ifdef DATA_SENDER_CHECKSUM_EN
    exp_q.push_back(m_cs);
`endif
  endtask

  // Stimulus tasks: entered at posedge+1, each pulse lasts one cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] c);
    CMD = c;
    SEND_HEADER = 1'b1;
    tick();
    SEND_HEADER = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] d, input logic [1:0] n);
    DATA_IN = d;
    DATA_NBYTES = n;
    SEND_DATA = 1'b1;
    tick();
    SEND_DATA = 1'b0;
  endtask

  task automatic send_trl();
    SEND_TRAILER = 1'b1;
    tick();
    SEND_TRAILER = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    tick();
    while (BUSY_SEND && n < budget) begin
      tick();
      n++;
    end
    chk("idle", 32'(BUSY_SEND), 32'd0);
  endtask

  task automatic wait_bytes(input int cnt, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chk("bytes_seen", 32'(rx_q.size() >= cnt), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    chk($sformatf("%s_len", tag), 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    $display("frame %s: %0d bytes received, %0d expected", tag, rx_q.size(), exp_q.size());
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    RST_N = 1'b0;
    CMD = '0;
    SEND_HEADER = 1'b0;
    SEND_DATA = 1'b0;
    SEND_TRAILER = 1'b0;
    DATA_IN = '0;
    DATA_NBYTES = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", 32'(TX_VALID), 32'd0);
    chk("rst_byte", 32'(TX_BYTE), 32'h00);
    chk("rst_busy", 32'(BUSY_SEND), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    tick();

    // Plain header; busy rises next cycle and drops once the last byte goes.
    ready_mode = 1;
    tick();
    send_hdr(32'h12345678);
    chk("hdr_busy_next", 32'(BUSY_SEND), 32'd1);
    exp_q = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};
    wait_bytes(5, 100);
    chk("hdr_busy_after", 32'(BUSY_SEND), 32'd0);
    chk("hdr_valid_after", 32'(TX_VALID), 32'd0);
    wait_idle(100);
    compare_stream("hdr");

    // Header, one 2-byte word, trailer.
    send_hdr(32'h12345678);
    send_data(32'hA1B2C3D4, 2'd1);
    send_trl();
    exp_q = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'hC3, 8'hD4, 8'h55, 8'h00, 8'h01};
`ifdef DATA_SENDER_CHECKSUM_EN
    exp_q.push_back(8'h17);
`endif
    wait_idle(200);
    compare_stream("hdr_data_trl");

    // Link stalls 10 cycles on the third header byte.
    send_hdr(32'h12345678);
    wait_bytes(2, 100);
    ready_mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_byte", 32'(TX_BYTE), 32'h34);
      chk("stall_valid", 32'(TX_VALID), 32'd1);
    end
    ready_mode = 1;
    exp_q = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};
    wait_idle(100);
    compare_stream("stall");

    // Six back-to-back words with the link blocked: one in flight, four queued, one dropped.
    begin
      logic [31:0] d [6];
      logic [1:0]  n [6];
      logic [31:0] c;
      ready_mode = 0;
      tick();
      for (int i = 0; i < 6; i++) begin
        d[i] = $urandom;
        n[i] = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < 6; i++) send_data(d[i], n[i]);
      chk("ovf_set", 32'(OVERFLOW), 32'd1);
      c = $urandom;
      send_hdr(c);
      send_trl();
      tick();
      chk("ovf_held", 32'(OVERFLOW), 32'd1);
      exp_data(d[0], n[0]);
      exp_hdr(c);
      for (int i = 1; i < 5; i++) exp_data(d[i], n[i]);
      exp_trl();
      ready_mode = 1;
      wait_idle(300);
      chk("ovf_cleared", 32'(OVERFLOW), 32'd0);
      compare_stream("overflow");
    end

    // Randomized frames under random link readiness.
    ready_mode = 2;
    for (int s = 0; s < 30; s++) begin
      logic [31:0] c;
      int k;
      int dbl;
      c = $urandom;
      k = $urandom_range(0, 4);
      dbl = $urandom_range(0, 1);
      send_hdr(c);
      exp_hdr(c);
      for (int w = 0; w < k; w++) begin
        logic [31:0] d;
        logic [1:0]  n;
        d = $urandom;
        n = 2'($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) tick();
        send_data(d, n);
        exp_data(d, n);
      end
      send_trl();
      if (dbl != 0) send_trl();
      exp_trl();
      $display("scenario %0d: cmd=%h words=%0d repeat_trailer=%0d", s, c, k, dbl);
      wait_idle(1000);
      compare_stream($sformatf("rand%0d", s));
    end

    // Trailer requested with three words still queued behind a blocked header.
    begin
      logic [31:0] c;
      ready_mode = 0;
      tick();
      c = $urandom;
      send_hdr(c);
      exp_hdr(c);
      for (int i = 0; i < 3; i++) begin
        logic [31:0] d;
        logic [1:0]  n;
        d = $urandom;
        n = 2'($urandom_range(0, 3));
        send_data(d, n);
        exp_data(d, n);
      end
      send_trl();
      exp_trl();
      ready_mode = 1;
      wait_idle(300);
      compare_stream("trl_after_3");
    end

    // Reset in the middle of a 4-byte word, then fresh frames.
    ready_mode = 1;
    send_data(32'hCAFEBABE, 2'd3);
    wait_bytes(2, 100);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_valid", 32'(TX_VALID), 32'd0);
    chk("mid_rst_byte", 32'(TX_BYTE), 32'h00);
    chk("mid_rst_busy", 32'(BUSY_SEND), 32'd0);
    chk("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    rx_q.delete();
    exp_q.delete();
    m_wc = 16'h0;
    m_cs = 8'h00;
    tick();
    send_trl();
    exp_trl();
    wait_idle(100);
    compare_stream("post_rst_trl");
    begin
      logic [31:0] c;
      c = $urandom;
      send_hdr(c);
      exp_hdr(c);
      send_data(32'h0BADF00D, 2'd2);
      exp_data(32'h0BADF00D, 2'd2);
      send_trl();
      exp_trl();
      wait_idle(200);
      compare_stream("post_rst_frame");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sender_sm.md
DATA_SENDER_SM -- requirements
Module: data_sender_sm

Interface
REQ-001 SHALL have port CLK  input  1  system clock (50 MHz).
REQ-002 SHALL have port RST_N  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port CMD  input  32  command word, sampled on SEND_HEADER.
REQ-004 SHALL have port SEND_HEADER  input  1  one-cycle request: emit header frame.
REQ-005 SHALL have port SEND_DATA  input  1  one-cycle request: queue one data word.
REQ-006 SHALL have port SEND_TRAILER  input  1  one-cycle request: emit trailer frame.
REQ-007 SHALL have port DATA_IN  input  32  data word, sampled on SEND_DATA.
REQ-008 SHALL have port DATA_NBYTES  input  2  bytes to send minus one (0..3 = 1..4 bytes), sampled on SEND_DATA.
REQ-009 SHALL have port BUSY_SEND  output  1  high while any request is pending or in progress.
REQ-010 SHALL have port TX_BYTE  output  8  byte to PC link.
REQ-011 SHALL have port TX_VALID  output  1  TX_BYTE valid.
REQ-012 SHALL have port TX_READY  input  1  link accepts byte.
REQ-013 SHALL have port OVERFLOW  output  1  sticky: a SEND_DATA was dropped.

Function
REQ-014 SHALL transfer a byte only on a cycle with TX_VALID=1 and TX_READY=1; TX_BYTE and TX_VALID SHALL stay stable until that cycle.
REQ-015 SHALL emit header as 5 bytes: 0xAA, CMD[31:24], CMD[23:16], CMD[15:8], CMD[7:0].
REQ-016 SHALL emit each data word as DATA_NBYTES+1 bytes, MSB-first, starting at byte index DATA_NBYTES of DATA_IN.
REQ-017 SHALL emit trailer as: 0x55, word_count[15:8], word_count[7:0], then checksum byte when enabled (REQ-029).
REQ-018 SHALL push SEND_DATA into a 4-entry FIFO of {DATA_NBYTES, DATA_IN}; SEND_DATA is accepted in any state.
REQ-019 SHALL, on SEND_DATA while the FIFO is full, drop the word and set OVERFLOW; a simultaneous pop frees no slot for the same cycle.
REQ-020 SHALL latch SEND_HEADER and SEND_TRAILER into pending flags; a repeat request while its flag is set is ignored.
REQ-021 SHALL use states IDLE, HDR, DATA, TRL; from IDLE the priority is header pending > FIFO non-empty > trailer pending.
REQ-022 SHALL return HDR/DATA/TRL to IDLE on the cycle the last byte of the frame transfers.
REQ-023 SHALL send the trailer only when the FIFO is empty; data queued before the trailer is always flushed first.
REQ-024 SHALL drive BUSY_SEND from registered state only: high when state!=IDLE, any pending flag is set, or the FIFO is non-empty; it SHALL be high on the cycle after any accepted SEND_* pulse.
REQ-025 SHALL clear word_count, checksum and OVERFLOW when the header frame starts.
REQ-026 SHALL increment word_count (16 bit, saturating at 0xFFFF) when a data word's last byte transfers.
REQ-027 SHALL XOR every transferred data byte into checksum (8 bit); header and trailer bytes are excluded.

Reset
REQ-028 SHALL, on RST_N low, force state IDLE, FIFO empty, pending flags 0, word_count 0, checksum 0, OVERFLOW 0, TX_VALID 0, TX_BYTE 0x00, BUSY_SEND 0; a frame in progress is abandoned.

Configuration
REQ-029 SHALL honour macro DATA_SENDER_CHECKSUM_EN: defined -> trailer is 4 bytes with the checksum last; undefined -> trailer is 3 bytes and the checksum logic is absent.

Structure
REQ-030 SHALL place the SOF (0xAA) and EOF (0x55) constants, the state encoding, the FIFO depth (4) and the header/trailer lengths in shared package data_sender_pkg.
REQ-031 SHALL implement the FIFO as sub-module send_fifo (depth 4, width 34, push/pop/full/empty).

Verification
REQ-032 SHALL cover: CMD=0x12345678, SEND_HEADER, TX_READY=1 -> bytes AA 12 34 56 78; BUSY_SEND high the next cycle and low after the last byte.
REQ-033 SHALL cover: header, then SEND_DATA DATA_IN=0xA1B2C3D4 NBYTES=1, then SEND_TRAILER -> AA.. C3 D4 55 00 01 17 (checksum 17 with macro; trailer ends at 01 without).
REQ-034 SHALL cover: TX_READY held low 10 cycles mid-header -> TX_BYTE unchanged; no byte lost or duplicated.
REQ-035 SHALL cover: 6 back-to-back SEND_DATA with TX_READY=0 -> 4 words queued, OVERFLOW=1, next header clears it.
REQ-036 SHALL cover: SEND_TRAILER while 3 words queued -> all 3 words sent first, trailer word_count=3.
REQ-037 SHALL cover: RST_N asserted mid data word -> all outputs at reset values; a new header afterwards is sent correctly.
